// File: rtl/leg_solver_pkg.sv
// Shared definitions for the leg solver: default width, fixed latency and
// the controller state encoding.
package leg_solver_pkg;

   localparam int W_DEFAULT = 8;

   // Cycles from the accept edge to the cycle in which done is high.
   localparam int LATENCY = 3 * W_DEFAULT + 2;

   typedef enum logic [2:0] {
      IDLE,
      SQ_R,
      SQ_X,
      SUB,
      ROOT,
      DONE
   } state_t;

endpackage

// File: rtl/leg_solver_seq_squarer.sv
// Sequential shift-add squarer. The load cycle folds in multiplier bit 0,
// so a W-bit square needs the load plus W-1 step cycles. The product is
// held while neither load nor step is asserted.
module seq_squarer #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   operand,
   output logic [2*W-1:0] product
);

   logic [2*W-1:0] mcand_reg;
   logic [W-1:0]   mplier_reg;
   logic [2*W-1:0] acc_reg;

   // Shift-add accumulation, one multiplier bit per cycle, LSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
      end else if (load) begin
         mcand_reg  <= {{(W-1){1'b0}}, operand, 1'b0};
         mplier_reg <= {1'b0, operand[W-1:1]};
         acc_reg    <= operand[0] ? {{W{1'b0}}, operand} : '0;
      end else if (step) begin
         if (mplier_reg[0]) begin
            acc_reg <= acc_reg + mcand_reg;
         end
         mcand_reg  <= {mcand_reg[2*W-2:0], 1'b0};
         mplier_reg <= {1'b0, mplier_reg[W-1:1]};
      end
   end

   assign product = acc_reg;

endmodule

// File: rtl/leg_solver.sv
// Leg solver: y = floor(sqrt(r*r - x*x)) with a fixed-latency iterative
// datapath. One squarer is reused for r then x; the restoring square root
// lives here. x > r flags err and yields y = 0 without shortening latency.
module leg_solver
   import leg_solver_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] r_in,
   input  logic [W-1:0] x_in,
   output logic [W-1:0] y_out,
   output logic         done,
   output logic         busy,
   output logic         err
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_t         state_reg, state_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic           cnt_last;

   logic           sq_load, sq_step;
   logic [W-1:0]   sq_operand;
   logic [2*W-1:0] sq_product;

   logic [W-1:0]   x_reg;
   logic [2*W-1:0] rsq_reg;
   logic [2*W-1:0] d_reg;
   logic [W+1:0]   rem_reg;
   logic [W-1:0]   root_reg;
   logic           err_flag_reg;
   logic [W-1:0]   y_reg;
   logic           err_reg;
   logic           done_reg;

   logic [1:0]     pair;
   logic [W+3:0]   rem_pair;
   logic [W+3:0]   sub_val;
   logic           trial_ok;
   logic [W+1:0]   trial;

   assign cnt_last = (cnt_reg == CW'(W - 1));

   // In IDLE the squarer is fed straight from r_in so that the accept edge
   // also performs the first squaring step; x is reloaded from its latch.
   assign sq_operand = (state_reg == SQ_R) ? x_reg : r_in;

   seq_squarer #(.W(W)) u_sq (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (sq_load),
      .step    (sq_step),
      .operand (sq_operand),
      .product (sq_product)
   );

   // Restoring sqrt trial: bring down the next pair and test against 4*root+1.
   assign pair     = d_reg[2*W-1 -: 2];
   assign rem_pair = {rem_reg, pair};
   assign sub_val  = {2'b00, root_reg, 2'b01};
   assign trial_ok = (rem_pair >= sub_val);
   assign trial    = rem_pair[W+1:0] - sub_val[W+1:0];

   // Controller state and phase counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state sequencing and squarer control.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sq_load    = 1'b0;
      sq_step    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = SQ_R;
               cnt_next   = '0;
               sq_load    = 1'b1;
            end
         end
         SQ_R: begin
            if (cnt_last) begin
               state_next = SQ_X;
               cnt_next   = '0;
               sq_load    = 1'b1;
            end else begin
               sq_step  = 1'b1;
               cnt_next = cnt_reg + 1'b1;
            end
         end
         SQ_X: begin
            if (cnt_last) begin
               state_next = SUB;
               cnt_next   = '0;
            end else begin
               sq_step  = 1'b1;
               cnt_next = cnt_reg + 1'b1;
            end
         end
         SUB: begin
            state_next = ROOT;
            cnt_next   = '0;
         end
         ROOT: begin
            if (cnt_last) begin
               state_next = DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Operand latch, difference, square-root iteration and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg        <= '0;
         rsq_reg      <= '0;
         d_reg        <= '0;
         rem_reg      <= '0;
         root_reg     <= '0;
         err_flag_reg <= 1'b0;
         y_reg        <= '0;
         err_reg      <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  x_reg <= x_in;
               end
            end
            SQ_R: begin
               if (cnt_last) begin
                  rsq_reg <= sq_product;
               end
            end
            SUB: begin
               if (rsq_reg >= sq_product) begin
                  d_reg        <= rsq_reg - sq_product;
                  err_flag_reg <= 1'b0;
               end else begin
                  d_reg        <= '0;
                  err_flag_reg <= 1'b1;
               end
               rem_reg  <= '0;
               root_reg <= '0;
            end
            ROOT: begin
               d_reg <= {d_reg[2*W-3:0], 2'b00};
               if (trial_ok) begin
                  rem_reg <= trial;
               end else begin
                  rem_reg <= rem_pair[W+1:0];
               end
               root_reg <= {root_reg[W-2:0], trial_ok};
            end
            DONE: begin
               y_reg    <= root_reg;
               err_reg  <= err_flag_reg;
               done_reg <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Busy spans the whole operation including the cycle done is shown.
   assign busy  = (state_reg != IDLE) | done_reg;
   assign done  = done_reg;
   assign y_out = y_reg;
   assign err   = err_reg;

endmodule

// File: tb/tb_leg_solver.sv
// Self-checking bench for leg_solver: directed cases, a random sweep, a
// start-held-high run and mid-operation resets against an arithmetic model.
module tb_leg_solver;
   import leg_solver_pkg::*;

   localparam int W   = W_DEFAULT;
   localparam int LAT = LATENCY;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] r_in = '0;
   logic [W-1:0] x_in = '0;
   logic [W-1:0] y_out;
   logic         done;
   logic         busy;
   logic         err;

   int total = 0;
   int bad   = 0;

   leg_solver #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .r_in  (r_in),
      .x_in  (x_in),
      .y_out (y_out),
      .done  (done),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: integer floor sqrt of max(r^2 - x^2, 0) by plain search.
   function automatic int ref_leg(input int r, input int x, output bit e);
      int d;
      int y;
      if (x > r) begin
         e = 1'b1;
         d = 0;
      end else begin
         e = 1'b0;
         d = r * r - x * x;
      end
      y = 0;
      while ((y + 1) * (y + 1) <= d) y++;
      return y;
   endfunction

   task automatic do_op(input int r, input int x, input bit repulse, input string tag);
      int dcyc;
      int ndone;
      int busy_bad;
      int ey;
      bit ee;
      dcyc = -1;
      ndone = 0;
      busy_bad = 0;
      ey = ref_leg(r, x, ee);
      @(negedge clk);
      r_in  = 8'(r);
      x_in  = 8'(x);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!repulse) begin
         r_in = 8'($urandom_range(255));
         x_in = 8'($urandom_range(255));
      end
      for (int k = 0; k <= LAT + 4; k++) begin
         if (done === 1'b1) begin
            ndone++;
            if (dcyc < 0) dcyc = k;
         end
         if (busy !== (k <= LAT)) busy_bad++;
         if (repulse && k == 5) begin
            start = 1'b1;
            r_in  = 8'd13;
            x_in  = 8'd5;
         end
         if (repulse && k == 7) start = 1'b0;
         @(posedge clk);
         #1;
      end
      $display("op %s r=%0d x=%0d -> y=%0d err=%0d done_cycle=%0d", tag, r, x, y_out, err, dcyc);
      check({tag, " latency"}, dcyc, LAT);
      check({tag, " done_count"}, ndone, 1);
      check({tag, " busy_window"}, busy_bad, 0);
      check({tag, " y"}, 32'(y_out), ey);
      check({tag, " err"}, 32'(err), 32'(ee));
   endtask

   task automatic abort_op(input int r, input int x, input int at, input string tag);
      int ndone;
      @(negedge clk);
      r_in  = 8'(r);
      x_in  = 8'(x);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < at; k++) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check({tag, " rst y"}, 32'(y_out), 0);
      check({tag, " rst busy"}, 32'(busy), 0);
      check({tag, " rst done"}, 32'(done), 0);
      check({tag, " rst err"}, 32'(err), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < LAT + 6; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) ndone++;
      end
      $display("abort %s r=%0d x=%0d at cycle %0d", tag, r, x, at);
      check({tag, " no_done"}, ndone, 0);
      check({tag, " idle_busy"}, 32'(busy), 0);
   endtask

   initial begin
      int ey;
      bit ee;
      int exp_y[$];
      int exp_e[$];
      int ndone;
      int last_done;
      int period_bad;
      int rr;
      int xx;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset y", 32'(y_out), 0);
      check("reset done", 32'(done), 0);
      check("reset busy", 32'(busy), 0);
      check("reset err", 32'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Directed cases.
      do_op(5, 3, 1'b0, "r5x3");
      do_op(13, 5, 1'b0, "r13x5");
      do_op(10, 3, 1'b0, "r10x3");
      do_op(255, 1, 1'b0, "r255x1");
      do_op(255, 0, 1'b0, "r255x0");
      do_op(10, 10, 1'b0, "r10x10");
      do_op(0, 0, 1'b0, "r0x0");
      do_op(3, 5, 1'b0, "r3x5_err");

      // Restart attempt while busy is ignored.
      do_op(5, 3, 1'b1, "repulse");
      do_op(13, 5, 1'b0, "after_repulse");

      // Mid-operation reset: once with err set, once with a large y held.
      do_op(3, 5, 1'b0, "pre_abort_err");
      abort_op(5, 3, 12, "abort1");
      do_op(255, 0, 1'b0, "pre_abort_y");
      abort_op(5, 3, 12, "abort2");
      do_op(5, 4, 1'b0, "post_abort");

      // Random sweep.
      for (int i = 0; i < 40; i++) begin
         do_op(int'($urandom_range(255)), int'($urandom_range(255)), 1'b0, "rand");
      end

      // start held high: back-to-back operations every LAT+1 cycles.
      ndone = 0;
      last_done = -1;
      period_bad = 0;
      @(negedge clk);
      rr = int'($urandom_range(255));
      xx = int'($urandom_range(255));
      r_in = 8'(rr);
      x_in = 8'(xx);
      ey = ref_leg(rr, xx, ee);
      exp_y.push_back(ey);
      exp_e.push_back(int'(ee));
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 5 * (LAT + 1); k++) begin
         if (done === 1'b1) begin
            if (ndone == 0) begin
               if (k != LAT) period_bad++;
            end else if (k - last_done != LAT + 1) begin
               period_bad++;
            end
            last_done = k;
            ndone++;
            $display("held op %0d -> y=%0d err=%0d at cycle %0d", ndone, y_out, err, k);
            check("held y", 32'(y_out), exp_y.pop_front());
            check("held err", 32'(err), exp_e.pop_front());
            if (ndone < 4) begin
               rr = int'($urandom_range(255));
               xx = int'($urandom_range(255));
               r_in = 8'(rr);
               x_in = 8'(xx);
               ey = ref_leg(rr, xx, ee);
               exp_y.push_back(ey);
               exp_e.push_back(int'(ee));
            end else begin
               start = 1'b0;
            end
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("held done_count", ndone, 4);
      check("held period", period_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/leg_solver.md
Name: leg_solver

Overview:
- Inverse of the team's hypotenuse block: given hypotenuse r and one leg x, computes the other leg y = floor(sqrt(r*r - x*x)).
- Multi-cycle iterative engine: shift-add squaring, subtract, then restoring digit-by-digit square root.
- Start/busy/done handshake with fixed latency. Sits beside the magnitude block so a sequencer can round-trip (x,y) -> r -> y.

Parameters:
- W, 8, operand/result width; squares and difference are 2W bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- r_in  in  W  hypotenuse operand
- x_in  in  W  known leg operand
- y_out  out  W  result leg; held until next accepted start
- done  out  1  one-cycle pulse, result valid
- busy  out  1  high from accept edge until done edge inclusive
- err  out  1  set with done when x > r; held with y_out

Behaviour:
- Reset (async assert, sync-released internal state): y_out=0, done=0, busy=0, err=0, FSM=IDLE, all datapath regs 0.
- States: IDLE -> SQ_R (W cycles) -> SQ_X (W cycles) -> SUB (1) -> ROOT (W cycles) -> DONE (1) -> IDLE.
- IDLE: on clk edge with start=1, capture r_in and x_in, busy<=1, go to SQ_R. start=0 means stay.
- SQ_R / SQ_X: shift-add squaring, one multiplier bit per cycle, LSB first; 2W-bit accumulator, no overflow possible ((2^W-1)^2 < 2^2W).
- SUB:
  - If rsq >= xsq: d <= rsq - xsq, err_next=0.
  - Else: d <= 0, err_next=1.
  - The error path keeps the fixed latency.
- ROOT: restoring integer sqrt. Each cycle consumes 2 bits of d (MSB pair first), trial = {rem, pair} - {root, 2'b01}. If trial is non-negative, rem <= trial and root bit=1; else root bit=0. rem is W+2 bits.
- DONE:
  - Outputs: y_out <= root, err <= err_next, done <= 1 for exactly this cycle.
  - busy falls on the edge after the done cycle; FSM returns to IDLE.
- Latency: for start accepted at edge 0, done is high in cycle 3W+2 (26 for W=8). A new start is accepted at the earliest on the edge ending the done cycle+1, i.e. while back in IDLE.
- start while busy: ignored, no queueing. Operand changes after the accept edge have no effect.
- start held high continuously: one new operation is accepted each time the FSM reaches IDLE.
- Reset mid-operation: immediate abort. Outputs return to reset values and no done is issued.
- x = r gives y=0, err=0. r = 0, x = 0 gives y=0, err=0.
- Result is floor, never rounded. It must satisfy y*y <= d < (y+1)*(y+1).

Decomposition:
- Shared package leg_solver_pkg holds:
  - FSM state enum (IDLE, SQ_R, SQ_X, SUB, ROOT, DONE).
  - LATENCY constant = 3*W+2.
  - Default W.
- One sub-module, seq_squarer: W-cycle shift-add squarer with load/step inputs and a 2W-bit product. It is instantiated once and reused for r then x.
- Sqrt datapath stays in the top module.

Test Plan:
- r=5, x=3, start pulse -> done in cycle 26, y_out=4, err=0, busy high for cycles 0..26.
- r=13, x=5 -> y_out=12. r=10, x=3 (d=91) -> y_out=9. r=255, x=1 (d=65024) -> y_out=254. r=255, x=0 -> y_out=255.
- Boundaries: r=10, x=10 -> y_out=0, err=0. r=3, x=5 -> y_out=0, err=1, done still in cycle 26.
- start re-pulsed with r=13, x=5 during an r=5, x=3 operation -> ignored. Single done, y_out=4. Next start after done -> y_out=12.
- rst_n asserted at cycle 12 of an operation -> y_out/busy/done/err go to 0 asynchronously and no done follows. A post-release start with r=5, x=4 -> y_out=3.
- Random sweep of all (r,x) with W=8 against reference model floor(sqrt(max(r^2-x^2,0))), plus an err check. done period with start tied high is 27 cycles.
